// File: rtl/systolic_skew_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : systolic_skew_feeder_if
// Description : Load port, edge operand buses and PE control strobes of the
//               systolic skew feeder.
// Revision    : 1.0 - initial release
// ============================================================================
interface systolic_skew_feeder_if #(
    parameter int N    = 32,
    parameter int SIZE = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [N-1:0]        in_data;
    logic                start;
    logic [SIZE*N-1:0]   a_edge;
    logic [SIZE*N-1:0]   b_edge;
    logic                edge_valid;
    logic                pe_clr;
    logic                pe_read;
    logic                pe_write;
    logic                busy;
    logic                done;

    // Host / array side
    modport master (
        output in_valid, in_data, start,
        input  in_ready, a_edge, b_edge, edge_valid,
        input  pe_clr, pe_read, pe_write, busy, done
    );

    // Feeder side
    modport slave (
        input  in_valid, in_data, start,
        output in_ready, a_edge, b_edge, edge_valid,
        output pe_clr, pe_read, pe_write, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module      : systolic_skew_feeder
// Description : Buffers one SIZE x SIZE tile of A and of B, then streams them
//               into the west/north edges of a systolic array with diagonal
//               skew, framed by an accumulator clear and a read/write strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_skew_feeder #(
    parameter int N    = 32,
    parameter int SIZE = 4
) (
    input  wire logic              clk,
    input  wire logic              clr,
    systolic_skew_feeder_if.slave  bus
);
    localparam int c_WORDS = 2 * SIZE * SIZE;
    localparam int c_LDW   = $clog2(c_WORDS);
    localparam int c_KW    = $clog2(3 * SIZE - 2);
    localparam int c_KLAST = 3 * SIZE - 3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READY  = 3'd1,
        S_CLEAR  = 3'd2,
        S_STREAM = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    state_t             r_state, w_next_state;
    logic [c_LDW-1:0]   r_ld_cnt, w_next_ld;
    logic [c_KW-1:0]    r_k, w_next_k;
    logic [N-1:0]       r_tile [c_WORDS];

    logic               r_in_ready;
    logic [SIZE*N-1:0]  r_a_edge, r_b_edge;
    logic [SIZE*N-1:0]  w_a_edge, w_b_edge;
    logic               r_edge_valid, r_pe_clr, r_pe_rw, r_busy;
    logic               w_accept;

    // A word is taken only while the registered ready is high (IDLE only)
    assign w_accept = bus.in_valid & r_in_ready;

    // State, load counter and stream index registers
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state  <= S_IDLE;
            r_ld_cnt <= '0;
            r_k      <= '0;
        end else begin
            r_state  <= w_next_state;
            r_ld_cnt <= w_next_ld;
            r_k      <= w_next_k;
        end
    end

    // Next-state logic: load, wait for start, clear, stream, drain
    always_comb begin
        w_next_state = r_state;
        w_next_ld    = r_ld_cnt;
        w_next_k     = r_k;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (r_ld_cnt == c_LDW'(c_WORDS - 1)) begin
                        w_next_state = S_READY;
                        w_next_ld    = '0;
                    end else begin
                        w_next_ld = r_ld_cnt + 1'b1;
                    end
                end
            end
            S_READY: begin
                if (bus.start) w_next_state = S_CLEAR;
            end
            S_CLEAR: begin
                w_next_state = S_STREAM;
                w_next_k     = '0;
            end
            S_STREAM: begin
                if (r_k == c_KW'(c_KLAST)) begin
                    w_next_state = S_DRAIN;
                    w_next_k     = '0;
                end else begin
                    w_next_k = r_k + 1'b1;
                end
            end
            S_DRAIN: w_next_state = S_READY;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Tile storage, row-major A words followed by row-major B words
    always_ff @(posedge clk) begin
        if (clr && w_accept) r_tile[r_ld_cnt] <= bus.in_data;
    end

    // Skewed lane selection for the stream cycle about to be presented;
    // lanes outside the diagonal window are forced to zero
    always_comb begin
        w_a_edge = '0;
        w_b_edge = '0;
        if (w_next_state == S_STREAM) begin
            for (int i = 0; i < SIZE; i++) begin
                if ((int'(w_next_k) >= i) && (int'(w_next_k) - i < SIZE)) begin
                    w_a_edge[i*N +: N] = r_tile[c_LDW'(i*SIZE + int'(w_next_k) - i)];
                    w_b_edge[i*N +: N] = r_tile[c_LDW'(SIZE*SIZE + (int'(w_next_k) - i)*SIZE + i)];
                end
            end
        end
    end

    // Outputs registered from the next state so they align with it
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_in_ready   <= 1'b1;
            r_a_edge     <= '0;
            r_b_edge     <= '0;
            r_edge_valid <= 1'b0;
            r_pe_clr     <= 1'b0;
            r_pe_rw      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_in_ready   <= (w_next_state == S_IDLE);
            r_a_edge     <= w_a_edge;
            r_b_edge     <= w_b_edge;
            r_edge_valid <= (w_next_state == S_STREAM);
            r_pe_clr     <= (w_next_state == S_CLEAR);
            r_pe_rw      <= (w_next_state == S_DRAIN);
            r_busy       <= (w_next_state != S_IDLE) && (w_next_state != S_READY);
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.a_edge     = r_a_edge;
    assign bus.b_edge     = r_b_edge;
    assign bus.edge_valid = r_edge_valid;
    assign bus.pe_clr     = r_pe_clr;
    assign bus.pe_read    = r_pe_rw;
    assign bus.pe_write   = r_pe_rw;
    assign bus.done       = r_pe_rw;
    assign bus.busy       = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_skew_feeder
// Description : Directed bench for the skew feeder: SIZE=2 skew/replay/reset
//               scenarios and a SIZE=4 run checked against a PE grid model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_skew_feeder;
    logic clk = 1'b0;
    logic clr;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    systolic_skew_feeder_if #(.N(32), .SIZE(2)) bus2 ();
    systolic_skew_feeder_if #(.N(32), .SIZE(4)) bus4 ();

    systolic_skew_feeder #(.N(32), .SIZE(2)) dut2 (.clk(clk), .clr(clr), .bus(bus2.slave));
    systolic_skew_feeder #(.N(32), .SIZE(4)) dut4 (.clk(clk), .clr(clr), .bus(bus4.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Load words base+1..base+8 into the SIZE=2 feeder, optionally with a gap
    task automatic load2(input int base, input bit gap);
        for (int w = 1; w <= 8; w++) begin
            if (gap && w == 5) begin
                bus2.in_valid = 1'b0;
                repeat (3) tick();
                chk("ld_gap_ready", {127'd0, bus2.in_ready}, 128'd1);
            end
            bus2.in_valid = 1'b1;
            bus2.in_data  = 32'(base + w);
            tick();
            if (w == 7) chk("ld_ready_w7", {127'd0, bus2.in_ready}, 128'd1);
        end
        bus2.in_valid = 1'b0;
        chk("ld_ready_full", {127'd0, bus2.in_ready}, 128'd0);
    endtask

    // Start a run on the SIZE=2 feeder and check the full skewed stream
    task automatic run2(input int base, input bit poke);
        logic [63:0] ea [4];
        logic [63:0] eb [4];
        ea[0] = {32'd0,          32'(base + 1)};
        ea[1] = {32'(base + 3),  32'(base + 2)};
        ea[2] = {32'(base + 4),  32'd0};
        ea[3] = 64'd0;
        eb[0] = {32'd0,          32'(base + 5)};
        eb[1] = {32'(base + 6),  32'(base + 7)};
        eb[2] = {32'(base + 8),  32'd0};
        eb[3] = 64'd0;
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        chk("clr_pe_clr", {127'd0, bus2.pe_clr}, 128'd1);
        chk("clr_busy", {127'd0, bus2.busy}, 128'd1);
        chk("clr_edge_valid", {127'd0, bus2.edge_valid}, 128'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            bus2.start = 1'b0;
            chk("str_valid", {127'd0, bus2.edge_valid}, 128'd1);
            chk("str_pe_clr", {127'd0, bus2.pe_clr}, 128'd0);
            chk("str_a_edge", {64'd0, bus2.a_edge}, {64'd0, ea[k]});
            chk("str_b_edge", {64'd0, bus2.b_edge}, {64'd0, eb[k]});
            chk("str_done", {127'd0, bus2.done}, 128'd0);
            if (poke && k == 1) bus2.start = 1'b1;
        end
        tick();
        chk("drn_done", {127'd0, bus2.done}, 128'd1);
        chk("drn_rd", {127'd0, bus2.pe_read}, 128'd1);
        chk("drn_wr", {127'd0, bus2.pe_write}, 128'd1);
        chk("drn_busy", {127'd0, bus2.busy}, 128'd1);
        chk("drn_valid", {127'd0, bus2.edge_valid}, 128'd0);
        tick();
        chk("rdy_done", {127'd0, bus2.done}, 128'd0);
        chk("rdy_busy", {127'd0, bus2.busy}, 128'd0);
        chk("rdy_in_ready", {127'd0, bus2.in_ready}, 128'd0);
    endtask

    logic [31:0] ta  [4][4];
    logic [31:0] tbm [4][4];
    logic [31:0] pa  [4][4];
    logic [31:0] pb  [4][4];
    logic [31:0] acc [4][4];
    logic [31:0] cref;
    int          nvalid;
    bit          seen_done;

    initial begin
        clr = 1'b0;
        bus2.in_valid = 1'b1; bus2.start = 1'b1; bus2.in_data = 32'hDEAD;
        bus4.in_valid = 1'b0; bus4.start = 1'b0; bus4.in_data = 32'd0;

        // Reset held with load and start asserted
        tick(); tick();
        chk("rst_in_ready", {127'd0, bus2.in_ready}, 128'd1);
        chk("rst_a_edge", {64'd0, bus2.a_edge}, 128'd0);
        chk("rst_b_edge", {64'd0, bus2.b_edge}, 128'd0);
        chk("rst_valid", {127'd0, bus2.edge_valid}, 128'd0);
        chk("rst_pe_clr", {127'd0, bus2.pe_clr}, 128'd0);
        chk("rst_pe_rw", {126'd0, bus2.pe_read, bus2.pe_write}, 128'd0);
        chk("rst_busy_done", {126'd0, bus2.busy, bus2.done}, 128'd0);
        clr = 1'b1;
        bus2.in_valid = 1'b0; bus2.start = 1'b0;
        tick();
        chk("post_rst_ready", {127'd0, bus2.in_ready}, 128'd1);

        // Load 1..8 and check the skewed stream
        load2(0, 1'b0);
        run2(0, 1'b0);

        // Load attempts in READY are ignored
        bus2.in_valid = 1'b1; bus2.in_data = 32'd99;
        tick();
        chk("rdy_ignore_ready", {127'd0, bus2.in_ready}, 128'd0);
        tick();
        chk("rdy_ignore_busy", {127'd0, bus2.busy}, 128'd0);
        bus2.in_valid = 1'b0;

        // Replay without reload, with a start poked mid-stream
        run2(0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_second_run", {126'd0, bus2.pe_clr, bus2.done}, 128'd0);
        end

        // Reset at stream cycle k=1
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        tick(); tick();
        chk("mid_k1_valid", {127'd0, bus2.edge_valid}, 128'd1);
        clr = 1'b0;
        tick();
        chk("mid_a_edge", {64'd0, bus2.a_edge}, 128'd0);
        chk("mid_b_edge", {64'd0, bus2.b_edge}, 128'd0);
        chk("mid_valid", {127'd0, bus2.edge_valid}, 128'd0);
        chk("mid_done", {127'd0, bus2.done}, 128'd0);
        chk("mid_busy", {127'd0, bus2.busy}, 128'd0);
        chk("mid_in_ready", {127'd0, bus2.in_ready}, 128'd1);
        clr = 1'b1;
        tick();
        chk("mid_no_done", {127'd0, bus2.done}, 128'd0);

        // Fresh load with a 3-cycle gap, then the stream of the new tiles
        load2(10, 1'b1);
        run2(10, 1'b0);

        // SIZE=4 random tiles through a PE grid model
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                ta[r][c]  = 32'($urandom_range(0, 255));
                tbm[r][c] = 32'($urandom_range(0, 255));
                pa[r][c]  = 32'd0;
                pb[r][c]  = 32'd0;
                acc[r][c] = 32'd0;
            end
        end
        for (int w = 0; w < 32; w++) begin
            bus4.in_valid = 1'b1;
            bus4.in_data  = (w < 16) ? ta[w/4][w%4] : tbm[(w-16)/4][w%4];
            tick();
        end
        bus4.in_valid = 1'b0;
        chk("s4_loaded", {127'd0, bus4.in_ready}, 128'd0);
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        chk("s4_pe_clr", {127'd0, bus4.pe_clr}, 128'd1);
        nvalid    = 0;
        seen_done = 1'b0;
        for (int cyc = 0; cyc < 20 && !seen_done; cyc++) begin
            tick();
            if (bus4.done) begin
                seen_done = 1'b1;
            end else begin
                if (bus4.edge_valid) nvalid++;
                for (int i = 0; i < 4; i++) begin
                    for (int j = 3; j >= 0; j--)
                        pa[i][j] = (j == 0) ? bus4.a_edge[i*32 +: 32] : pa[i][j-1];
                end
                for (int j = 0; j < 4; j++) begin
                    for (int i = 3; i >= 0; i--)
                        pb[i][j] = (i == 0) ? bus4.b_edge[j*32 +: 32] : pb[i-1][j];
                end
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++)
                        acc[i][j] = acc[i][j] + 32'(pa[i][j] * pb[i][j]);
            end
        end
        chk("s4_done_seen", {127'd0, seen_done}, 128'd1);
        chk("s4_stream_len", 128'(nvalid), 128'd10);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                cref = 32'd0;
                for (int m = 0; m < 4; m++) cref = cref + 32'(ta[i][m] * tbm[m][j]);
                chk("s4_c_elem", {96'd0, acc[i][j]}, {96'd0, cref});
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Operand feeder for the west and north edges of the SIZE×SIZE systolic array of Processing_Elements. It buffers one SIZE×SIZE tile of A and one SIZE×SIZE tile of B, loaded word by word through a valid/ready port. On `start` it clears the PE accumulators, then streams the tiles into the array with diagonal skew. It pulses the PE read/write controls once the last operand pair has entered the array.

## Interface
Parameters:
- `N`, 32, operand word width in bits (matches PE `N`)
- `SIZE`, 4, array dimension; also the tile edge length (SIZE ≥ 2)

Ports:
- `clk` in 1: single clock; everything is on the rising edge
- `clr` in 1: synchronous, active-low reset
- `in_valid` in 1: load word present
- `in_ready` out 1: feeder accepts a load word this cycle
- `in_data` in N: load word
- `start` in 1: begin a streaming run (honoured only in READY)
- `a_edge` out SIZE*N: west-edge operands; lane i = bits [i*N +: N] drives row i `A`
- `b_edge` out SIZE*N: north-edge operands; lane j = bits [j*N +: N] drives column j `B`
- `edge_valid` out 1: `a_edge`/`b_edge` carry a stream cycle
- `pe_clr` out 1: accumulator clear to all PEs
- `pe_read` out 1: PE read strobe
- `pe_write` out 1: PE write strobe
- `busy` out 1: state is not IDLE and not READY
- `done` out 1: one-cycle pulse at end of run

## Operation
- States: IDLE, READY, CLEAR, STREAM, DRAIN.
- **IDLE:**
  - `in_ready`=1.
  - Each cycle with `in_valid`=1 stores `in_data` and increments `ld_cnt`.
  - Words are taken row-major: words 0..SIZE²−1 are A[r][c]; words SIZE²..2·SIZE²−1 are B[r][c].
  - On the acceptance of word 2·SIZE²−1, go to READY with `ld_cnt`=0.
- **READY:**
  - `in_ready`=0. `in_valid` is ignored.
  - `start`=1 → CLEAR. Otherwise stay in READY.
  - The tiles persist, so one load may be streamed any number of times.
- **CLEAR:** exactly 1 cycle. `pe_clr`=1, then → STREAM with `k`=0.
- **STREAM:** 3·SIZE−2 cycles, k = 0..3·SIZE−3, with `edge_valid`=1.
  - Lane i of `a_edge` = A[i][k−i] if 0 ≤ k−i < SIZE, else 0.
  - Lane j of `b_edge` = B[k−j][j] if 0 ≤ k−j < SIZE, else 0.
  - After k=3·SIZE−3 → DRAIN.
- **DRAIN:** exactly 1 cycle. `pe_read`=1, `pe_write`=1, `done`=1, then → READY.
- `start` outside READY is ignored; it is not queued.
- To load a new tile pair, the feeder must be back in IDLE, which only reset achieves. Reset is the only way back to IDLE after the first load.
- Lane index arithmetic is unsigned. Out-of-window lanes drive exact zero so the PEs accumulate nothing from them.

## Timing
- All outputs are registered.
- Reset values: `in_ready`=1, `a_edge`=0, `b_edge`=0, `edge_valid`=0, `pe_clr`=0, `pe_read`=0, `pe_write`=0, `busy`=0, `done`=0, state IDLE, `ld_cnt`=0, `k`=0.
- Tile contents are don't-care after reset.
- Load: one word per cycle at full rate. A word is accepted on the edge where `in_valid`&`in_ready`=1.
- Run latency for `start` sampled in READY at edge t:
  - `pe_clr` is high in cycle t+1.
  - Stream cycle k appears in cycle t+2+k.
  - `done`/`pe_read`/`pe_write` are high in cycle t+3·SIZE.
  - `in_ready` is 0 throughout the run.
- `busy`=1 from cycle t+1 through the DRAIN cycle inclusive.
- `clr`=0 mid-run (any state): on the next edge every output returns to its reset value. No `done` is issued, and a partially loaded tile is discarded.
- `start` and `in_valid` asserted together in IDLE: only the load is processed.

## Test plan
- **Reset:** hold `clr`=0 for 2 cycles with `in_valid`=1 and `start`=1 → all outputs at reset values, `in_ready`=1, no word counted.
- **Load and skew, SIZE=2, N=32:**
  - Stimulus: load 1,2,3,4,5,6,7,8, then `start`.
  - `pe_clr` is high for 1 cycle.
  - `a_edge` lanes (row0,row1) = (1,0),(2,3),(0,4),(0,0).
  - `b_edge` lanes (col0,col1) = (5,0),(7,6),(0,8),(0,0).
  - The next cycle has `done`=`pe_read`=`pe_write`=1, then state is READY.
- **Back-pressure and gaps:**
  - Stimulus: drop `in_valid` for 3 cycles mid-load.
  - Word order is preserved and the stream matches the skew scenario.
  - `in_valid`=1 in READY is ignored: `in_ready`=0 and the tile is unchanged.
- **Replay:** issue `start` again after `done` → identical stream without reloading. `start` during STREAM is ignored, so there is exactly one `done` per accepted start.
- **Reset mid-STREAM:** assert `clr`=0 at k=1 → outputs are zero on the next edge, no `done`, state is IDLE, and a fresh 8-word load is accepted.
- **SIZE=4 sweep:** use random tiles and a bench model of a 4×4 PE grid → the accumulated C equals A·B, and the stream lasts 10 cycles.
